// File: rtl/pipe_reg_chain_if.sv
// Valid/ready/data handshake bundle used on both sides of pipe_reg_chain.
// The master drives valid and data and observes ready; the slave does the reverse.
interface pipe_reg_chain_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface : pipe_reg_chain_if

// File: rtl/pipe_reg_chain.sv
// Elastic DEPTH-stage pipeline register chain with valid/ready back-pressure,
// a one-cycle synchronous flush and an optional input skid buffer that turns
// the upstream ready into a registered signal.
//
// Each stage holds a valid bit and a payload word. A stage may load whenever
// it is empty or the stage after it is also moving, so bubbles collapse and a
// full chain still streams one word per cycle with out_ready held high.
// Bubbles never overwrite payload data; only the valid bit moves for them.
//
// With REG_READY=1 the upstream ready depends only on the skid buffer state,
// so the long out_ready -> in_ready combinational path is cut. A word that
// arrives while stage 0 is blocked waits in the skid and feeds stage 0 first
// once it frees up, keeping strict FIFO order.
module pipe_reg_chain #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               REG_READY = 1'b0,
    localparam int              OCC_W     = $clog2(DEPTH + 2)
) (
    input  logic                  clk,
    input  logic                  reset,      // asynchronous, active low
    input  logic                  flush,
    pipe_reg_chain_if.slave       s_in,
    pipe_reg_chain_if.master      m_out,
    output logic [OCC_W-1:0]      occupancy
);

    // ------------------------------------------------------------------
    // Stage storage
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] r_valid;
    logic [WIDTH-1:0] r_data [DEPTH];

    // Per-stage load enable: stage i may take a new word when it or any
    // later stage is empty, or when the consumer is taking the last word.
    logic [DEPTH-1:0] w_rdy;

    // Source feeding each stage (stage 0 from the input or skid).
    logic             w_stg_src_valid [DEPTH];
    logic [WIDTH-1:0] w_stg_src_data  [DEPTH];

    // Stage 0 source as selected by the skid logic.
    logic             w_src_valid;
    logic [WIDTH-1:0] w_src_data;

    logic             w_in_ready;
    logic             w_in_fire;
    logic             w_skid_valid;
    logic [OCC_W-1:0] w_occ;

    // Ready chain as a reduction over later stages rather than a rippling
    // recurrence, so no combinational signal depends on itself.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rdy
        assign w_rdy[gi] = m_out.ready | ~(&r_valid[DEPTH-1:gi]);
    end

    // ------------------------------------------------------------------
    // Upstream handshake
    // ------------------------------------------------------------------
    // Ready is forced low while reset is held and during a flush cycle, so a
    // word offered in either case is simply not taken.
    if (REG_READY) begin : g_in_ready_reg
        assign w_in_ready = reset & ~flush & ~w_skid_valid;
    end else begin : g_in_ready_comb
        assign w_in_ready = reset & ~flush & w_rdy[0];
    end

    assign w_in_fire  = s_in.valid & w_in_ready;
    assign s_in.ready = w_in_ready;

    // ------------------------------------------------------------------
    // Optional skid buffer
    // ------------------------------------------------------------------
    if (REG_READY) begin : g_skid
        logic             r_skid_valid;
        logic [WIDTH-1:0] r_skid_data;

        // Capture an accepted word that stage 0 cannot take; release it as
        // soon as stage 0 frees up. Flush discards a parked word.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_skid_valid <= 1'b0;
                r_skid_data  <= RESET_VAL;
            end else if (flush) begin
                r_skid_valid <= 1'b0;
            end else if (r_skid_valid) begin
                if (w_rdy[0]) begin
                    r_skid_valid <= 1'b0;
                end
            end else if (w_in_fire && !w_rdy[0]) begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= s_in.data;
            end
        end

        // A parked word is always older than anything on the input, so it
        // has priority into stage 0 (the input is not ready meanwhile).
        assign w_skid_valid = r_skid_valid;
        assign w_src_valid  = r_skid_valid | w_in_fire;
        assign w_src_data   = r_skid_valid ? r_skid_data : s_in.data;
    end else begin : g_no_skid
        assign w_skid_valid = 1'b0;
        assign w_src_valid  = w_in_fire;
        assign w_src_data   = s_in.data;
    end

    // ------------------------------------------------------------------
    // Stage chain
    // ------------------------------------------------------------------
    // Route each stage's source: stage 0 from the input/skid, others from the
    // previous stage.
    always_comb begin
        // NOTE: every combinational output gets a value before any branch or
        // loop so no path leaves it unassigned and a latch is never inferred.
        for (int i = 0; i < DEPTH; i++) begin
            w_stg_src_valid[i] = 1'b0;
            w_stg_src_data[i]  = RESET_VAL;
        end
        w_stg_src_valid[0] = w_src_valid;
        w_stg_src_data[0]  = w_src_data;
        for (int i = 1; i < DEPTH; i++) begin
            w_stg_src_valid[i] = r_valid[i-1];
            w_stg_src_data[i]  = r_data[i-1];
        end
    end

    // Advance the chain: a ready stage takes its source's valid and, only for
    // a real word, its data. Flush kills every valid and freezes the data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: payload registers are reset too (not just the valids)
            // because out_data is visible and must read RESET_VAL after reset.
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= RESET_VAL;
            end
        end else if (flush) begin
            r_valid <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage read the
            // pre-edge value of its predecessor, so a word moves exactly one
            // stage per edge regardless of loop order.
            for (int i = 0; i < DEPTH; i++) begin
                if (w_rdy[i]) begin
                    r_valid[i] <= w_stg_src_valid[i];
                    if (w_stg_src_valid[i]) begin
                        r_data[i] <= w_stg_src_data[i];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Downstream side and occupancy
    // ------------------------------------------------------------------
    assign m_out.valid = r_valid[DEPTH-1];
    assign m_out.data  = r_data[DEPTH-1];

    // Count held words: one per valid stage plus a parked skid word.
    always_comb begin
        w_occ = OCC_W'(w_skid_valid);
        for (int i = 0; i < DEPTH; i++) begin
            w_occ = w_occ + OCC_W'(r_valid[i]);
        end
    end

    assign occupancy = w_occ;

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------
    a_occ_range: assert property (@(posedge clk) disable iff (!reset)
        int'(occupancy) <= DEPTH + int'(REG_READY));

    a_no_accept_on_flush: assert property (@(posedge clk) disable iff (!reset)
        flush |-> !s_in.ready);

    a_hold_when_blocked: assert property (@(posedge clk) disable iff (!reset)
        (m_out.valid && !m_out.ready && !flush) |=> m_out.valid);

endmodule : pipe_reg_chain

// File: tb/tb_pipe_reg_chain.sv
// Directed and randomised checks of pipe_reg_chain across four configurations
// driven from one shared stimulus. A queue per configuration holds the words
// that must still come out, in order.
`timescale 1ns/1ps
module tb_pipe_reg_chain;

    localparam int          NCFG          = 4;
    localparam int          CFG_W  [NCFG] = '{8, 32, 64, 32};
    localparam int          CFG_D  [NCFG] = '{2, 3, 3, 2};
    localparam int          CFG_RR [NCFG] = '{0, 0, 1, 1};
    localparam logic [63:0] CFG_RV [NCFG] = '{64'h5A, 64'h0,
                                              64'hFFFF_0000_1234_5678, 64'hCAFE_F00D};

    logic        clk         = 1'b0;
    logic        r_reset     = 1'b1;
    logic        r_flush     = 1'b0;
    logic        r_in_valid  = 1'b0;
    logic        r_out_ready = 1'b0;
    logic [63:0] r_in_data   = '0;

    logic        w_in_ready  [NCFG];
    logic        w_out_valid [NCFG];
    logic [63:0] w_out_data  [NCFG];
    int          w_occ       [NCFG];

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] q [NCFG][$];
    int          acc [NCFG];

    always #5 clk = ~clk;

    for (genvar k = 0; k < NCFG; k++) begin : g_cfg
        pipe_reg_chain_if #(.WIDTH(CFG_W[k])) u_in  ();
        pipe_reg_chain_if #(.WIDTH(CFG_W[k])) u_out ();
        logic [$clog2(CFG_D[k]+2)-1:0] w_occ_k;

        assign u_in.valid  = r_in_valid;
        assign u_in.data   = r_in_data[CFG_W[k]-1:0];
        assign u_out.ready = r_out_ready;

        pipe_reg_chain #(
            .WIDTH     (CFG_W[k]),
            .DEPTH     (CFG_D[k]),
            .RESET_VAL (CFG_RV[k][CFG_W[k]-1:0]),
            .REG_READY (CFG_RR[k] != 0)
        ) u_dut (
            .clk       (clk),
            .reset     (r_reset),
            .flush     (r_flush),
            .s_in      (u_in),
            .m_out     (u_out),
            .occupancy (w_occ_k)
        );

        assign w_in_ready[k]  = u_in.ready;
        assign w_out_valid[k] = u_out.valid;
        assign w_out_data[k]  = 64'(u_out.data);
        assign w_occ[k]       = int'(w_occ_k);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] mask(input int k, input logic [63:0] v);
        if (CFG_W[k] >= 64) return v;
        return v & ((64'd1 << CFG_W[k]) - 64'd1);
    endfunction

    // One clock cycle. Entered 1 ns after a rising edge with inputs already
    // set; checks the handshake before the edge, updates the model at the edge.
    task automatic step();
        logic exp_rdy;
        logic in_fire  [NCFG];
        logic out_fire [NCFG];
        #2;
        for (int k = 0; k < NCFG; k++) begin
            exp_rdy = r_reset && !r_flush &&
                      (q[k].size() < CFG_D[k] + CFG_RR[k] ||
                       (CFG_RR[k] == 0 && r_out_ready));
            check($sformatf("in_ready[%0d]", k), 64'(w_in_ready[k]), 64'(exp_rdy));
            check($sformatf("occupancy[%0d]", k), 64'(w_occ[k]), 64'(q[k].size()));
            if (q[k].size() == 0)
                check($sformatf("idle_out_valid[%0d]", k), 64'(w_out_valid[k]), 64'd0);
            in_fire[k]  = r_in_valid && exp_rdy;
            out_fire[k] = w_out_valid[k] && r_out_ready && q[k].size() != 0;
            if (out_fire[k])
                check($sformatf("out_data[%0d]", k), w_out_data[k], q[k][0]);
        end
        @(posedge clk);
        for (int k = 0; k < NCFG; k++) begin
            if (out_fire[k]) void'(q[k].pop_front());
            if (r_flush) q[k].delete();
            else if (in_fire[k]) q[k].push_back(mask(k, r_in_data));
        end
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        for (int k = 0; k < NCFG; k++) begin
            check($sformatf("%s_out_valid[%0d]", tag, k), 64'(w_out_valid[k]), 64'd0);
            check($sformatf("%s_out_data[%0d]", tag, k), w_out_data[k], mask(k, CFG_RV[k]));
            check($sformatf("%s_occ[%0d]", tag, k), 64'(w_occ[k]), 64'd0);
            check($sformatf("%s_in_ready[%0d]", tag, k), 64'(w_in_ready[k]), 64'd0);
        end
    endtask

    // Offer one word 0x11 from empty and check it appears after DEPTH edges.
    task automatic latency_probe(input string tag);
        r_out_ready = 1'b0;
        r_in_valid  = 1'b1;
        r_in_data   = 64'h11;
        step();
        r_in_valid  = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            for (int k = 0; k < NCFG; k++) begin
                check($sformatf("%s_valid_e%0d[%0d]", tag, e, k),
                      64'(w_out_valid[k]), 64'(e >= CFG_D[k]));
                if (e >= CFG_D[k])
                    check($sformatf("%s_data_e%0d[%0d]", tag, e, k), w_out_data[k], 64'h11);
            end
            if (e < 4) step();
        end
        r_out_ready = 1'b1;
        repeat (3) step();
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a word offered: nothing may be taken.
        r_in_valid = 1'b1;
        r_in_data  = 64'hDEAD_BEEF;
        #1 r_reset = 1'b0;
        #1 check_reset_state("rst");
        @(posedge clk); #1;
        step();
        step();
        check_reset_state("rst_held");
        r_reset = 1'b1;
        latency_probe("t1");

        // Back-to-back streaming with out_ready high.
        r_out_ready = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            r_in_valid = (e <= 8);
            r_in_data  = 64'(e);
            step();
            for (int k = 0; k < NCFG; k++) begin
                logic exp_v;
                exp_v = (e >= CFG_D[k]) && (e < CFG_D[k] + 8);
                check($sformatf("t2_valid_e%0d[%0d]", e, k), 64'(w_out_valid[k]), 64'(exp_v));
                if (exp_v)
                    check($sformatf("t2_data_e%0d[%0d]", e, k),
                          w_out_data[k], 64'(e - CFG_D[k] + 1));
            end
        end
        r_in_valid = 1'b0;

        // Back-pressure: fill until in_ready drops, then drain.
        r_out_ready = 1'b0;
        for (int k = 0; k < NCFG; k++) acc[k] = 0;
        for (int i = 0; i < 6; i++) begin
            r_in_valid = 1'b1;
            r_in_data  = 64'h100 + 64'(i);
            #1;
            for (int k = 0; k < NCFG; k++) if (w_in_ready[k]) acc[k]++;
            step();
        end
        r_in_valid = 1'b0;
        #1;
        for (int k = 0; k < NCFG; k++) begin
            check($sformatf("t3_accepted[%0d]", k), 64'(acc[k]), 64'(CFG_D[k] + CFG_RR[k]));
            check($sformatf("t3_occ_full[%0d]", k), 64'(w_occ[k]), 64'(CFG_D[k] + CFG_RR[k]));
            check($sformatf("t3_in_ready_full[%0d]", k), 64'(w_in_ready[k]), 64'd0);
        end
        r_out_ready = 1'b1;
        repeat (6) step();
        for (int k = 0; k < NCFG; k++)
            check($sformatf("t3_drained[%0d]", k), 64'(q[k].size()), 64'd0);

        // Flush with 0xA, 0xB held and 0xC offered.
        r_out_ready = 1'b0;
        r_in_valid  = 1'b1;
        r_in_data   = 64'hA;
        step();
        r_in_data   = 64'hB;
        step();
        r_flush     = 1'b1;
        r_in_data   = 64'hC;
        step();
        r_flush     = 1'b0;
        r_in_valid  = 1'b0;
        for (int k = 0; k < NCFG; k++) begin
            check($sformatf("t4_occ[%0d]", k), 64'(w_occ[k]), 64'd0);
            check($sformatf("t4_out_valid[%0d]", k), 64'(w_out_valid[k]), 64'd0);
        end
        r_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            for (int k = 0; k < NCFG; k++)
                check($sformatf("t4_no_c_%0d[%0d]", i, k), 64'(w_out_valid[k]), 64'd0);
        end

        // Random traffic; out_ready density alternates to reach full often.
        for (int c = 0; c < 1500; c++) begin
            r_in_valid  = ($urandom_range(0, 99) < 70);
            r_out_ready = ($urandom_range(0, 99) < (((c / 100) % 2 == 0) ? 25 : 85));
            r_flush     = ($urandom_range(0, 99) < 5);
            r_in_data   = {$urandom(), $urandom()};
            step();
        end
        r_flush = 1'b0;

        // Fill, then assert reset between edges.
        r_out_ready = 1'b0;
        r_in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            r_in_data = 64'h200 + 64'(i);
            step();
        end
        #3 r_reset = 1'b0;
        #1 check_reset_state("t6");
        for (int k = 0; k < NCFG; k++) q[k].delete();
        r_in_valid = 1'b0;
        @(posedge clk);
        #2 r_reset = 1'b1;
        @(posedge clk); #1;
        latency_probe("t6");
        for (int c = 0; c < 200; c++) begin
            r_in_valid  = ($urandom_range(0, 99) < 60);
            r_out_ready = ($urandom_range(0, 99) < 60);
            r_in_data   = {$urandom(), $urandom()};
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_pipe_reg_chain
